panda_lut_seq: RTL and testbench

Table-driven sequencer that programs the FUNC truth table of a panda_lut instance over time. It stores up to DEPTH FUNC words with per-entry repeat counts and steps through them on trigger edges, driving func_o straight into panda_lut.FUNC. This lets one LUT apply a timed series of logic functions without software rewriting FUNC mid-run.

---
 rtl/panda_lut_seq.sv | 172 +++++++++++++++++
 tb/tb_panda_lut_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/panda_lut_seq.sv
// panda_lut_seq: table-driven sequencer that steps a panda_lut FUNC word
// through a programmed list of entries, one repeat per trigger rising edge.
module panda_lut_seq #(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          enable_i,
    input  logic          trig_i,
    input  logic          TABLE_WSTB,
    input  logic [AW-1:0] TABLE_ADDR,
    input  logic [31:0]   TABLE_FUNC,
    input  logic [15:0]   TABLE_RPT,
    input  logic [4:0]    TABLE_LENGTH,
    input  logic [15:0]   TABLE_CYCLES,
    output logic [31:0]   func_o,
    output logic          active_o,
    output logic [AW-1:0] index_o,
    output logic [15:0]   rpt_o,
    output logic [15:0]   cycle_o
);

    localparam int unsigned LW = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [31:0]     func_mem_q [DEPTH];
    logic [15:0]     rpt_mem_q  [DEPTH];

    logic            en_q;
    logic            trig_q;
    logic            armed_q;
    logic [LW-1:0]   len_q;
    logic [15:0]     cycles_q;
    logic [31:0]     func_q;
    logic            active_q;
    logic [AW-1:0]   index_q;
    logic [15:0]     rpt_q;
    logic [15:0]     cycle_q;

    logic            en_rise;
    logic            trig_edge;
    logic [LW-1:0]   eff_len;
    logic            last_entry;
    logic [AW-1:0]   next_idx;
    logic [AW-1:0]   load_idx;
    logic            load_hit;
    logic [31:0]     load_func;
    logic [15:0]     load_rpt_raw;
    logic [15:0]     load_rpt;
    logic [15:0]     cycle_inc;
    logic            run_finished;

    // Edge detection, length clamp and entry-load selection (write-first on the loaded entry)
    always_comb begin
        // armed_q blocks a spurious rise when enable_i is already high coming out of reset
        en_rise      = enable_i & ~en_q & armed_q;
        trig_edge    = trig_i & ~trig_q;
        eff_len      = (TABLE_LENGTH > LW'(DEPTH)) ? LW'(DEPTH) : TABLE_LENGTH;
        last_entry   = (LW'(index_q) == (len_q - LW'(1)));
        next_idx     = last_entry ? '0 : (index_q + AW'(1));
        load_idx     = (state_q == S_RUN) ? next_idx : '0;
        load_hit     = TABLE_WSTB && (TABLE_ADDR == load_idx);
        load_func    = load_hit ? TABLE_FUNC : func_mem_q[load_idx];
        load_rpt_raw = load_hit ? TABLE_RPT  : rpt_mem_q[load_idx];
        load_rpt     = (load_rpt_raw == 16'd0) ? 16'd1 : load_rpt_raw;
        cycle_inc    = (cycle_q == 16'hFFFF) ? cycle_q : (cycle_q + 16'd1);
        run_finished = (cycles_q != 16'd0) &&
                       ((17'(cycle_q) + 17'd1) == 17'(cycles_q));
    end

    // Table storage; writes accepted in any state
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                func_mem_q[i] <= '0;
                rpt_mem_q[i]  <= '0;
            end
        end else if (TABLE_WSTB) begin
            func_mem_q[TABLE_ADDR] <= TABLE_FUNC;
            rpt_mem_q[TABLE_ADDR]  <= TABLE_RPT;
        end
    end

    // Sequencer state machine with registered outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            en_q     <= 1'b0;
            trig_q   <= 1'b0;
            armed_q  <= 1'b0;
            len_q    <= '0;
            cycles_q <= '0;
            func_q   <= '0;
            active_q <= 1'b0;
            index_q  <= '0;
            rpt_q    <= '0;
            cycle_q  <= '0;
        end else begin
            en_q   <= enable_i;
            trig_q <= trig_i;
            if (!enable_i) begin
                armed_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (en_rise && (eff_len != '0)) begin
                        state_q  <= S_RUN;
                        len_q    <= eff_len;
                        cycles_q <= TABLE_CYCLES;
                        active_q <= 1'b1;
                        index_q  <= '0;
                        func_q   <= load_func;
                        rpt_q    <= load_rpt;
                        cycle_q  <= '0;
                    end
                end
                S_RUN: begin
                    if (!enable_i) begin
                        state_q  <= S_IDLE;
                        active_q <= 1'b0;
                        func_q   <= '0;
                        index_q  <= '0;
                        rpt_q    <= '0;
                        cycle_q  <= '0;
                    end else if (trig_edge) begin
                        if (rpt_q > 16'd1) begin
                            rpt_q <= rpt_q - 16'd1;
                        end else if (last_entry && run_finished) begin
                            state_q  <= S_DONE;
                            active_q <= 1'b0;
                            func_q   <= '0;
                            rpt_q    <= '0;
                            cycle_q  <= cycle_inc;
                        end else begin
                            index_q <= next_idx;
                            func_q  <= load_func;
                            rpt_q   <= load_rpt;
                            if (last_entry) begin
                                cycle_q <= cycle_inc;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (!enable_i) begin
                        state_q <= S_IDLE;
                        index_q <= '0;
                        rpt_q   <= '0;
                        cycle_q <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign func_o   = func_q;
    assign active_o = active_q;
    assign index_o  = index_q;
    assign rpt_o    = rpt_q;
    assign cycle_o  = cycle_q;

endmodule

// File: tb/tb_panda_lut_seq.sv
// tb_panda_lut_seq: directed-vector bench for panda_lut_seq.
module tb_panda_lut_seq;

    logic        clk_i;
    logic        reset_i;
    logic        enable_i;
    logic        trig_i;
    logic        TABLE_WSTB;
    logic [3:0]  TABLE_ADDR;
    logic [31:0] TABLE_FUNC;
    logic [15:0] TABLE_RPT;
    logic [4:0]  TABLE_LENGTH;
    logic [15:0] TABLE_CYCLES;
    logic [31:0] func_o;
    logic        active_o;
    logic [3:0]  index_o;
    logic [15:0] rpt_o;
    logic [15:0] cycle_o;

    int n_cmp;
    int n_bad;

    panda_lut_seq #(.DEPTH(16)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .enable_i     (enable_i),
        .trig_i       (trig_i),
        .TABLE_WSTB   (TABLE_WSTB),
        .TABLE_ADDR   (TABLE_ADDR),
        .TABLE_FUNC   (TABLE_FUNC),
        .TABLE_RPT    (TABLE_RPT),
        .TABLE_LENGTH (TABLE_LENGTH),
        .TABLE_CYCLES (TABLE_CYCLES),
        .func_o       (func_o),
        .active_o     (active_o),
        .index_o      (index_o),
        .rpt_o        (rpt_o),
        .cycle_o      (cycle_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] f, input logic a,
                             input logic [3:0] i, input logic [15:0] r, input logic [15:0] c);
        check({tag, ".func"},   func_o,           f);
        check({tag, ".active"}, 32'(active_o),    32'(a));
        check({tag, ".index"},  32'(index_o),     32'(i));
        check({tag, ".rpt"},    32'(rpt_o),       32'(r));
        check({tag, ".cycle"},  32'(cycle_o),     32'(c));
    endtask

    // Advance one clock; inputs change and outputs are sampled at the falling edge
    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] f, input logic [15:0] r);
        TABLE_WSTB = 1'b1;
        TABLE_ADDR = a;
        TABLE_FUNC = f;
        TABLE_RPT  = r;
        tick();
        TABLE_WSTB = 1'b0;
    endtask

    task automatic pulse();
        trig_i = 1'b1;
        tick();
        trig_i = 1'b0;
        tick();
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        reset_i      = 1'b1;
        enable_i     = 1'b0;
        trig_i       = 1'b0;
        TABLE_WSTB   = 1'b0;
        TABLE_ADDR   = '0;
        TABLE_FUNC   = '0;
        TABLE_RPT    = '0;
        TABLE_LENGTH = '0;
        TABLE_CYCLES = '0;
        tick();
        check_all("reset", 32'h0, 1'b0, 4'd0, 16'd0, 16'd0);
        reset_i = 1'b0;
        tick();

        // Basic sequence, with a trig edge coincident with the enable rise
        wr(4'd0, 32'hAAAAAAAA, 16'd1);
        wr(4'd1, 32'h0000FFFF, 16'd2);
        wr(4'd2, 32'hFFFFFFFF, 16'd0);
        TABLE_LENGTH = 5'd3;
        TABLE_CYCLES = 16'd1;
        enable_i = 1'b1;
        trig_i   = 1'b1;
        tick();
        check_all("start", 32'hAAAAAAAA, 1'b1, 4'd0, 16'd1, 16'd0);
        trig_i = 1'b0;
        tick();
        pulse();
        check_all("trig1", 32'h0000FFFF, 1'b1, 4'd1, 16'd2, 16'd0);
        pulse();
        check_all("trig2", 32'h0000FFFF, 1'b1, 4'd1, 16'd1, 16'd0);
        pulse();
        check_all("trig3", 32'hFFFFFFFF, 1'b1, 4'd2, 16'd1, 16'd0);
        pulse();
        check_all("done", 32'h0, 1'b0, 4'd2, 16'd0, 16'd1);
        pulse();
        check_all("done_hold", 32'h0, 1'b0, 4'd2, 16'd0, 16'd1);
        enable_i = 1'b0;
        tick();
        check_all("done_idle", 32'h0, 1'b0, 4'd0, 16'd0, 16'd0);

        // Wrap and infinite run
        wr(4'd0, 32'h11111111, 16'd1);
        wr(4'd1, 32'h22222222, 16'd1);
        TABLE_LENGTH = 5'd2;
        TABLE_CYCLES = 16'd0;
        enable_i = 1'b1;
        tick();
        check_all("inf_start", 32'h11111111, 1'b1, 4'd0, 16'd1, 16'd0);
        for (int k = 1; k <= 10; k++) begin
            pulse();
            check("inf.index", 32'(index_o), 32'(k % 2));
            check("inf.cycle", 32'(cycle_o), 32'(k / 2));
        end
        check_all("inf_end", 32'h11111111, 1'b1, 4'd0, 16'd1, 16'd5);

        // Abort with a coincident trig edge
        enable_i = 1'b0;
        trig_i   = 1'b1;
        tick();
        check_all("abort", 32'h0, 1'b0, 4'd0, 16'd0, 16'd0);
        trig_i = 1'b0;
        tick();

        // LENGTH = 0 never starts a run
        TABLE_LENGTH = 5'd0;
        enable_i = 1'b1;
        tick();
        check_all("len0", 32'h0, 1'b0, 4'd0, 16'd0, 16'd0);
        enable_i = 1'b0;
        tick();

        // LENGTH = 31 clamps to 16 entries
        for (int i = 0; i < 16; i++) begin
            wr(4'(i), 32'h100 + 32'(i), 16'd1);
        end
        TABLE_LENGTH = 5'd31;
        enable_i = 1'b1;
        tick();
        check_all("clamp_start", 32'h100, 1'b1, 4'd0, 16'd1, 16'd0);
        for (int k = 1; k <= 16; k++) begin
            pulse();
            check("clamp.index", 32'(index_o), 32'(k % 16));
            check("clamp.func", func_o, 32'h100 + 32'(k % 16));
        end
        check("clamp.cycle", 32'(cycle_o), 32'd1);

        // Live write to the active entry only shows on the next pass
        pulse();
        check("live.pre", func_o, 32'h101);
        wr(4'd1, 32'hDEADBEEF, 16'd1);
        check_all("live.hold", 32'h101, 1'b1, 4'd1, 16'd1, 16'd1);
        for (int k = 0; k < 15; k++) begin
            pulse();
        end
        check("live.wrap_idx", 32'(index_o), 32'd0);
        pulse();
        check_all("live.new", 32'hDEADBEEF, 1'b1, 4'd1, 16'd1, 16'd2);

        // Write to the entry being loaded in the same cycle: new value wins
        TABLE_WSTB = 1'b1;
        TABLE_ADDR = 4'd2;
        TABLE_FUNC = 32'hCAFEF00D;
        TABLE_RPT  = 16'd3;
        trig_i     = 1'b1;
        tick();
        TABLE_WSTB = 1'b0;
        trig_i     = 1'b0;
        tick();
        check_all("wfirst", 32'hCAFEF00D, 1'b1, 4'd2, 16'd3, 16'd2);

        // Reset mid-run at index 2, then enable must toggle before a new run
        reset_i = 1'b1;
        #1;
        check_all("rst_mid", 32'h0, 1'b0, 4'd0, 16'd0, 16'd0);
        tick();
        reset_i = 1'b0;
        tick();
        tick();
        check_all("rst_noarm", 32'h0, 1'b0, 4'd0, 16'd0, 16'd0);
        enable_i = 1'b0;
        tick();
        enable_i = 1'b1;
        tick();
        check_all("rst_rearm", 32'h0, 1'b1, 4'd0, 16'd1, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
